// File: rtl/bf16_add_arb_if.sv
// Requester and result bundle for bf16_add_arb.
// Carries req_sub_i only when BF16_ADD_ARB_SUB_EN is defined.
interface bf16_add_arb_if #(
  parameter int unsigned N = 4
);
  localparam int unsigned ID_W = $clog2(N);

  logic [N-1:0]      req_valid_i;
  logic [N-1:0]      req_ready_o;
  logic [16*N-1:0]   req_a_i;
  logic [16*N-1:0]   req_b_i;
`ifdef BF16_ADD_ARB_SUB_EN
  logic [N-1:0]      req_sub_i;
`endif
  logic              res_valid_o;
  logic              res_ready_i;
  logic [15:0]       res_o;
  logic [ID_W-1:0]   res_id_o;
  logic              busy_o;

  modport slave (
`ifdef BF16_ADD_ARB_SUB_EN
    input  req_sub_i,
`endif
    input  req_valid_i,
    output req_ready_o,
    input  req_a_i,
    input  req_b_i,
    output res_valid_o,
    input  res_ready_i,
    output res_o,
    output res_id_o,
    output busy_o
  );

  modport master (
`ifdef BF16_ADD_ARB_SUB_EN
    output req_sub_i,
`endif
    output req_valid_i,
    input  req_ready_o,
    output req_a_i,
    output req_b_i,
    input  res_valid_o,
    output res_ready_i,
    input  res_o,
    input  res_id_o,
    input  busy_o
  );
endinterface

// File: rtl/bf16_add_arb.sv
// Round-robin arbiter feeding a shared two-stage BFloat16 adder pipeline.
// Define BF16_ADD_ARB_SUB_EN to add per-requester subtract (a - b).
module bf16_add_arb #(
  parameter int unsigned N = 4
) (
  input logic          clk,
  input logic          nreset,
  bf16_add_arb_if.slave bus
);
  localparam int unsigned ID_W = $clog2(N);

  // Round-to-nearest-even add with subnormal support.
  function automatic logic [15:0] bf16_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x, y;
    logic [9:0]  ex, ey, e, d;
    logic [11:0] mx, my, s;
    logic        sticky, inc;
    logic [8:0]  r;
    if (a[14:0] >= b[14:0]) begin
      x = a;
      y = b;
    end else begin
      x = b;
      y = a;
    end
    if (x[14:7] == 8'hFF) begin
      if (x[6:0] != 7'd0) return 16'h7FC0;
      if (y[14:0] == 15'h7F80 && x[15] != y[15]) return 16'h7FC0;
      return x;
    end
    ex = (x[14:7] == 8'd0) ? 10'd1 : {2'b00, x[14:7]};
    ey = (y[14:7] == 8'd0) ? 10'd1 : {2'b00, y[14:7]};
    mx = {1'b0, x[14:7] != 8'd0, x[6:0], 3'b000};
    my = {1'b0, y[14:7] != 8'd0, y[6:0], 3'b000};
    d  = ex - ey;
    sticky = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i < int'(d)) begin
        sticky = sticky | my[0];
        my = {1'b0, my[11:1]};
      end
    end
    my[0] = my[0] | sticky;
    s = (x[15] == y[15]) ? mx + my : mx - my;
    if (s == 12'd0) return {x[15] & y[15], 15'd0};
    e = ex;
    if (s[11]) begin
      s = {1'b0, s[11:2], s[1] | s[0]};
      e = e + 10'd1;
    end else begin
      for (int i = 0; i < 11; i++) begin
        if (!s[10] && e > 10'd1) begin
          s = {s[10:0], 1'b0};
          e = e - 10'd1;
        end
      end
    end
    inc = s[2] & (s[1] | s[0] | s[3]);
    r = {1'b0, s[10:3]} + {8'd0, inc};
    if (r[8]) begin
      r = {1'b0, r[8:1]};
      e = e + 10'd1;
    end
    if (e >= 10'd255) return {x[15], 8'hFF, 7'd0};
    return {x[15], r[7] ? e[7:0] : 8'h00, r[6:0]};
  endfunction

  logic            v1_q, v1_d, v2_q, v2_d;
  logic [ID_W-1:0] rr_q, rr_d;
  logic [15:0]     a1_q, b1_q, sum2_q, b_eff, sum;
  logic [ID_W-1:0] id1_q, id2_q;
  logic            s2_free, s1_adv, s1_free;
  logic            gnt_vld;
  logic [ID_W-1:0] gnt_idx, idx;
  logic [N-1:0]    gnt;

  always_comb begin
    s2_free = !v2_q || bus.res_ready_i;
    s1_adv  = v1_q && s2_free;
    s1_free = !v1_q || s1_adv;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    gnt     = '0;
    // Walk downward so the requester closest to rr_q is written last and wins.
    for (int k = int'(N) - 1; k >= 0; k--) begin
      idx = ID_W'((int'(rr_q) + k) % int'(N));
      if (bus.req_valid_i[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
    if (!(s1_free && nreset)) gnt_vld = 1'b0;
    if (gnt_vld) gnt[gnt_idx] = 1'b1;

    rr_d = rr_q;
    if (gnt_vld) rr_d = (gnt_idx == ID_W'(N - 1)) ? '0 : gnt_idx + 1'b1;

    v1_d = v1_q;
    if (gnt_vld)     v1_d = 1'b1;
    else if (s1_adv) v1_d = 1'b0;

    v2_d = v2_q;
    if (s1_adv)                v2_d = 1'b1;
    else if (bus.res_ready_i)  v2_d = 1'b0;
  end

`ifdef BF16_ADD_ARB_SUB_EN
  logic sub1_q;
  always_ff @(posedge clk) begin
    if (gnt_vld) sub1_q <= bus.req_sub_i[gnt_idx];
  end
  assign b_eff = sub1_q ? {~b1_q[15], b1_q[14:0]} : b1_q;
`else
  assign b_eff = b1_q;
`endif

  assign sum = bf16_add(a1_q, b_eff);

  always_ff @(posedge clk) begin
    if (!nreset) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      rr_q <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      rr_q <= rr_d;
    end
  end

  // Data path carries no reset; the valid bits qualify it.
  always_ff @(posedge clk) begin
    if (gnt_vld) begin
      a1_q  <= bus.req_a_i[{gnt_idx, 4'b0000} +: 16];
      b1_q  <= bus.req_b_i[{gnt_idx, 4'b0000} +: 16];
      id1_q <= gnt_idx;
    end
    if (s1_adv) begin
      sum2_q <= sum;
      id2_q  <= id1_q;
    end
  end

  assign bus.req_ready_o = gnt;
  assign bus.res_valid_o = v2_q;
  assign bus.res_o       = sum2_q;
  assign bus.res_id_o    = id2_q;
  assign bus.busy_o      = v1_q | v2_q;
endmodule

// File: tb/tb_bf16_add_arb.sv
// Directed bench for bf16_add_arb with N = 4 and hand-computed BF16 sums.
module tb_bf16_add_arb;
  logic clk;
  logic nreset;
  int   n_pass;
  int   n_total;

  bf16_add_arb_if #(.N(4)) bus ();

  bf16_add_arb #(.N(4)) dut (
    .clk   (clk),
    .nreset(nreset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int i, input logic [15:0] a, input logic [15:0] b);
    bus.req_a_i[16*i +: 16] = a;
    bus.req_b_i[16*i +: 16] = b;
  endtask

  // Single op on an empty pipeline with res_ready_i high.
  task automatic run_op(input string tag, input int id, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] exp);
    int waited;
    set_slot(id, a, b);
    bus.req_valid_i = 4'(1 << id);
    #1;
    waited = 0;
    while (!bus.req_ready_o[id] && waited < 20) begin
      tick();
      waited++;
    end
    check({tag, "_rdy"}, 32'(bus.req_ready_o[id]), 32'd1);
    tick();
    bus.req_valid_i = 4'b0000;
    tick();
    check({tag, "_vld"}, 32'(bus.res_valid_o), 32'd1);
    check({tag, "_res"}, 32'(bus.res_o), 32'(exp));
    check({tag, "_id"}, 32'(bus.res_id_o), 32'(id));
    tick();
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    nreset = 1'b0;
    bus.req_valid_i = '0;
    bus.req_a_i = '0;
    bus.req_b_i = '0;
    bus.res_ready_i = 1'b1;
`ifdef BF16_ADD_ARB_SUB_EN
    bus.req_sub_i = '0;
`endif

    // Reset and idle
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_ready", 32'(bus.req_ready_o), 32'd0);
      check("rst_valid", 32'(bus.res_valid_o), 32'd0);
      check("rst_busy", 32'(bus.busy_o), 32'd0);
    end
    nreset = 1'b1;
    #1;
    check("idle_ready", 32'(bus.req_ready_o), 32'd0);
    check("idle_busy", 32'(bus.busy_o), 32'd0);

    set_slot(2, 16'h3F80, 16'h3F80);
    bus.req_valid_i = 4'b0100;
    #1;
    check("first_gnt", 32'(bus.req_ready_o), 32'h4);
    tick();
    bus.req_valid_i = 4'b0000;
    check("lat1_valid", 32'(bus.res_valid_o), 32'd0);
    check("lat1_busy", 32'(bus.busy_o), 32'd1);
    tick();
    check("lat2_valid", 32'(bus.res_valid_o), 32'd1);
    check("lat2_res", 32'(bus.res_o), 32'h4000);
    check("lat2_id", 32'(bus.res_id_o), 32'd2);
    tick();
    check("drain_valid", 32'(bus.res_valid_o), 32'd0);

    // Round-robin fairness from rr_ptr = 0
    nreset = 1'b0;
    tick();
    nreset = 1'b1;
    for (int i = 0; i < 4; i++) set_slot(i, 16'h0000, 16'h3F80);
    for (int c = 0; c < 12; c++) begin
      bus.req_valid_i = (c < 10) ? 4'hF : 4'h0;
      #1;
      if (c < 10) check("rr_gnt", 32'(bus.req_ready_o), 32'(1 << (c % 4)));
      if (c >= 2) begin
        check("rr_valid", 32'(bus.res_valid_o), 32'd1);
        check("rr_id", 32'(bus.res_id_o), 32'((c - 2) % 4));
        check("rr_res", 32'(bus.res_o), 32'h3F80);
      end
      tick();
    end
    check("rr_empty", 32'(bus.res_valid_o), 32'd0);

    // Backpressure from requester 1
    bus.res_ready_i = 1'b0;
    set_slot(1, 16'h3F80, 16'h3F80);
    bus.req_valid_i = 4'b0010;
    #1;
    check("bp_acc1", 32'(bus.req_ready_o), 32'h2);
    tick();
    set_slot(1, 16'h4000, 16'h3F80);
    #1;
    check("bp_acc2", 32'(bus.req_ready_o), 32'h2);
    tick();
    set_slot(1, 16'h0000, 16'h3F80);
    #1;
    check("bp_full", 32'(bus.req_ready_o), 32'd0);
    check("bp_valid", 32'(bus.res_valid_o), 32'd1);
    check("bp_res", 32'(bus.res_o), 32'h4000);
    check("bp_id", 32'(bus.res_id_o), 32'd1);
    tick();
    check("bp_hold_res", 32'(bus.res_o), 32'h4000);
    check("bp_hold_rdy", 32'(bus.req_ready_o), 32'd0);
    bus.res_ready_i = 1'b1;
    #1;
    check("bp_same_cyc", 32'(bus.req_ready_o), 32'h2);
    tick();
    bus.req_valid_i = 4'b0000;
    check("bp_res2", 32'(bus.res_o), 32'h4040);
    check("bp_vld2", 32'(bus.res_valid_o), 32'd1);
    tick();
    check("bp_res3", 32'(bus.res_o), 32'h3F80);
    check("bp_vld3", 32'(bus.res_valid_o), 32'd1);
    tick();
    check("bp_done", 32'(bus.res_valid_o), 32'd0);
    check("bp_idle", 32'(bus.busy_o), 32'd0);

    // Zero handling and a plain sum
    run_op("pz_nz", 0, 16'h0000, 16'h8000, 16'h0000);
    run_op("nz_one", 0, 16'h8000, 16'h3F80, 16'h3F80);
    run_op("nz_nz", 3, 16'h8000, 16'h8000, 16'h8000);
    run_op("cancel", 2, 16'h3F80, 16'hBF80, 16'h0000);
    run_op("two_one", 1, 16'h4000, 16'h3F80, 16'h4040);

    // Reset mid-flight
    bus.res_ready_i = 1'b0;
    set_slot(0, 16'h3F80, 16'h3F80);
    bus.req_valid_i = 4'b0001;
    tick();
    tick();
    check("mf_busy", 32'(bus.busy_o), 32'd1);
    check("mf_full", 32'(bus.res_valid_o), 32'd1);
    nreset = 1'b0;
    #1;
    check("mf_rst_rdy", 32'(bus.req_ready_o), 32'd0);
    tick();
    check("mf_rst_vld", 32'(bus.res_valid_o), 32'd0);
    check("mf_rst_busy", 32'(bus.busy_o), 32'd0);
    bus.req_valid_i = 4'b0000;
    bus.res_ready_i = 1'b1;
    nreset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mf_no_stale", 32'(bus.res_valid_o), 32'd0);
    end
    set_slot(1, 16'h4000, 16'h3F80);
    set_slot(3, 16'h3F80, 16'h3F80);
    bus.req_valid_i = 4'b1010;
    #1;
    check("mf_gnt", 32'(bus.req_ready_o), 32'h2);
    tick();
    bus.req_valid_i = 4'b0000;
    tick();
    check("mf_res", 32'(bus.res_o), 32'h4040);
    check("mf_id", 32'(bus.res_id_o), 32'd1);
    tick();

`ifdef BF16_ADD_ARB_SUB_EN
    bus.req_sub_i = 4'b1111;
    run_op("sub_2m1", 0, 16'h4000, 16'h3F80, 16'h3F80);
    run_op("sub_1m1", 2, 16'h3F80, 16'h3F80, 16'h0000);
    bus.req_sub_i = 4'b0000;
    run_op("sub_off", 2, 16'h3F80, 16'h3F80, 16'h4000);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end
endmodule
